// File: rtl/ws2812_encoder.sv
// WS2812 transmitter: serializes 24-bit GRB words MSB first into the NRZ line code
// and appends a latch low period whenever no word is ready at a word boundary.
module ws2812_encoder #(
  parameter int T0H_CYCLES    = 20,
  parameter int T1H_CYCLES    = 40,
  parameter int BIT_CYCLES    = 63,
  parameter int TRESET_CYCLES = 2750
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [23:0] i_data,
  input  logic        i_valid,
  output logic        o_ready,
  output logic        o_dout,
  output logic        o_busy
);

  localparam int MAX_CYCLES = (BIT_CYCLES > TRESET_CYCLES) ? BIT_CYCLES : TRESET_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BIT   = 2'd1,
    ST_LATCH = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [23:0]   shift_q, shift_d;
  logic [4:0]    bit_idx_q, bit_idx_d;
  logic [CW-1:0] phase_q, phase_d;
  logic          dout_q, dout_d;
  logic          last_bit_cycle;
  logic          bit_end;
  logic          latch_end;
  logic [CW-1:0] high_len;

  assign bit_end        = (phase_q == CW'(BIT_CYCLES - 1));
  assign latch_end      = (phase_q == CW'(TRESET_CYCLES - 1));
  assign last_bit_cycle = (state_q == ST_BIT) && bit_end && (bit_idx_q == 5'd0);

  assign o_ready = (state_q == ST_IDLE) || last_bit_cycle;
  assign o_busy  = (state_q != ST_IDLE);
  assign o_dout  = dout_q;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    phase_d   = phase_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          state_d   = ST_BIT;
          shift_d   = i_data;
          bit_idx_d = 5'd23;
          phase_d   = '0;
        end
      end
      ST_BIT: begin
        if (bit_end) begin
          phase_d = '0;
          if (bit_idx_q != 5'd0) begin
            shift_d   = {shift_q[22:0], 1'b0};
            bit_idx_d = bit_idx_q - 5'd1;
          end else if (i_valid) begin
            shift_d   = i_data;
            bit_idx_d = 5'd23;
          end else begin
            state_d = ST_LATCH;
          end
        end else begin
          phase_d = phase_q + CW'(1);
        end
      end
      ST_LATCH: begin
        if (latch_end) begin
          state_d = ST_IDLE;
          phase_d = '0;
        end else begin
          phase_d = phase_q + CW'(1);
        end
      end
      default: begin
        state_d   = ST_IDLE;
        shift_d   = '0;
        bit_idx_d = '0;
        phase_d   = '0;
      end
    endcase
  end

  // The line level is decoded from the next-cycle state so the pin comes straight off a flop.
  always_comb begin
    high_len = shift_d[23] ? CW'(T1H_CYCLES) : CW'(T0H_CYCLES);
    dout_d   = (state_d == ST_BIT) && (phase_d < high_len);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      phase_q   <= '0;
      dout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      phase_q   <= phase_d;
      dout_q    <= dout_d;
    end
  end

endmodule

// File: doc/ws2812_encoder.md
# ws2812_encoder

Serializes 24-bit GRB colour words into the WS2812 single-wire NRZ waveform and inserts the reset/latch low period at the end of each frame. It is the transmit end of the WS2812 pipeline: the receive path decodes line bits and captures 24-bit LED data, and this block regenerates line bits from 24-bit words. It drives the LED data pin, or the downstream chain, directly from a flop.

## Interface
- One clock; reset is asynchronous and active-low.
- Parameters:
  - T0H_CYCLES, default 20 — high time of a '0' bit (400 ns at 50 MHz).
  - T1H_CYCLES, default 40 — high time of a '1' bit (800 ns).
  - BIT_CYCLES, default 63 — total bit period (1.26 µs).
  - TRESET_CYCLES, default 2750 — latch low period (55 µs).
  - Legal: 0 < T0H_CYCLES < T1H_CYCLES < BIT_CYCLES; TRESET_CYCLES ≥ 1. Illegal values are not supported.
- Ports:
  - i_clk  input  1  system clock
  - i_reset_n  input  1  asynchronous active-low reset
  - i_data  input  24  colour word, {G[7:0], R[7:0], B[7:0]}, transmitted MSB (bit 23) first
  - i_valid  input  1  i_data is valid
  - o_ready  output  1  block accepts i_data this cycle
  - o_dout  output  1  WS2812 line, registered
  - o_busy  output  1  high whenever state ≠ IDLE

## Operation
- Handshake: a word transfers on any rising edge where i_valid && o_ready. i_valid while o_ready=0 is ignored; i_data is not sampled. Upstream holds the word.
- A transferred word is copied into an internal 24-bit shift register. Later changes on i_data have no effect on the word in flight.
- Counters:
  - bit index: 23→0.
  - phase counter: 0..BIT_CYCLES-1 during bits, 0..TRESET_CYCLES-1 during LATCH.
  - Counter width: $clog2(max(BIT_CYCLES, TRESET_CYCLES)).
- States:
  - IDLE:
    - o_dout=0, o_ready=1, o_busy=0.
    - On transfer → BIT with bit index 23, phase 0.
  - BIT:
    - o_dout=1 for phase < (current bit ? T1H_CYCLES : T0H_CYCLES), else 0.
    - At phase BIT_CYCLES-1: phase→0. If bit index > 0, shift and decrement the index.
    - If bit index = 0, the block is at the last phase of the last bit:
      - o_ready=1 during this single cycle only.
      - Transfer in this cycle → reload, bit index 23, stay in BIT. No gap between words.
      - No transfer → LATCH.
    - o_ready=0 in all other BIT cycles.
  - LATCH:
    - o_dout=0, o_ready=0, o_busy=1 for TRESET_CYCLES cycles, then → IDLE.
    - The latch period always completes and is not shortened by i_valid.
- Frame boundary is implicit: any gap in valid words at a word boundary produces a full latch.
- Unused state encodings → IDLE.

## Timing
- Reset values: o_dout=0, o_ready=1, o_busy=0, state IDLE, shift register and counters 0.
- Reset asserted mid-word or mid-latch forces all outputs to their reset values immediately (asynchronous). The in-flight word is discarded. After release, the next word starts from bit 23.
- Latency: transfer at edge N → o_dout=1 from the cycle after edge N. First high phase lasts exactly T0H_CYCLES or T1H_CYCLES cycles.
- Each bit occupies exactly BIT_CYCLES cycles; a word occupies 24·BIT_CYCLES cycles.
- Back-to-back words: the rising edge of bit 23 of word k+1 follows the last low cycle of word k with zero extra cycles.
- LATCH → IDLE: o_ready rises the cycle after the TRESET_CYCLES-th low latch cycle. o_dout is low for at least TRESET_CYCLES+1 cycles between frames.
- o_dout has no combinational path from any input.

## Test plan
Use small parameters: T0H=2, T1H=4, BIT=6, TRESET=10.
- Reset check: assert i_reset_n=0 → o_dout=0, o_ready=1, o_busy=0. Release with no i_valid → outputs unchanged for 100 cycles.
- Single word: send 24'hA50000 → o_dout shows pattern 1111_00, 11_0000, … for bits 1,0,1,0,0,1,0,1, then sixteen '0' bits (11_0000). Then 10 low LATCH cycles, then o_ready=1; total busy = 144+10 cycles.
- Back-to-back: send 24'hFFFFFF and 24'h000001 with i_valid held high → 48 contiguous bit periods, no extra low cycle at the word boundary. o_ready pulses high for exactly one cycle at cycle 143 of the first word. Single LATCH after the second word.
- Late word: the second word's i_valid rises one cycle after the last-bit ready pulse → full 10-cycle LATCH, then IDLE, then the second word starts. Line stays low for ≥ 11 cycles between words.
- Async reset mid-word: pulse i_reset_n low during bit 10 high phase → o_dout falls without a clock edge. A new word 24'h800000 after release → first bit high for 4 cycles.
- Busy stability: toggle i_valid and randomize i_data throughout a word and its LATCH → waveform matches only the accepted word; no transfer occurs while o_ready=0.
